// File: rtl/stack_arb_pkg.sv
// Shared definitions for the stack arbiter: op encoding and FSM state encoding.
package stack_arb_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first asserted request at or above ptr (mod NUM_REQ) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_sh;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   onehot_rot;
    logic [2*NUM_REQ-1:0] grant_dbl;
    logic                 found;

    // Rotate so ptr sits at bit 0, pick the lowest request, then rotate back.
    always_comb begin
        req_dbl    = {req, req};
        req_sh     = req_dbl >> ptr;
        req_rot    = req_sh[NUM_REQ-1:0];
        onehot_rot = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_rot[k] && !found) begin
                onehot_rot[k] = 1'b1;
                found         = 1'b1;
            end
        end
        grant_dbl = {onehot_rot, onehot_rot} << ptr;
        grant     = grant_dbl[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one circular stack between NUM_REQ requesters with occupancy tracking.
// Define STACK_ARB_WRAP_EN to let a push on a full stack overwrite the oldest entry.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int STACK_WIDTH = 18,
    parameter int STACK_SIZE  = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_op,
    input  logic [NUM_REQ*STACK_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [STACK_WIDTH-1:0]         o_rsp_data,
    output logic                           o_rsp_err,
    output logic                           o_stk_push,
    output logic                           o_stk_pop,
    output logic [STACK_WIDTH-1:0]         o_stk_data,
    input  logic [STACK_WIDTH-1:0]         i_stk_data,
    output logic [STACK_SIZE:0]            o_count,
    output logic                           o_full,
    output logic                           o_empty,
    output state_e                         o_state
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [STACK_SIZE:0] DEPTH = {1'b1, {STACK_SIZE{1'b0}}};
`ifdef STACK_ARB_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    // Handshake: a command transfers on the rising edge where i_req_valid[i] & o_req_ready[i];
    // the requester holds valid/op/data stable until then, and ready is offered only in IDLE.
    state_e                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       owner;
    logic [PTR_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic                   sel_op;
    logic [STACK_WIDTH-1:0] sel_data;
    logic                   push_ok;
    logic                   pop_ok;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign o_req_ready = (state == IDLE && !i_rst) ? grant : '0;
    assign o_full      = (o_count == DEPTH);
    assign o_empty     = (o_count == '0);
    assign o_state     = state;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
        sel_op   = i_req_op[grant_idx];
        sel_data = i_req_data[grant_idx*STACK_WIDTH +: STACK_WIDTH];
        push_ok  = !o_full || WRAP_EN;
        pop_ok   = !o_empty;
    end

    // Legality is decided on the accept edge; o_count cannot move until CMD ends,
    // so this is the same count seen at the start of CMD.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            o_count     <= '0;
            o_stk_push  <= 1'b0;
            o_stk_pop   <= 1'b0;
            o_stk_data  <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|o_req_ready) begin
                        owner  <= grant_idx;
                        rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                        if (sel_op == OP_PUSH) begin
                            o_stk_push <= push_ok;
                            o_stk_data <= push_ok ? sel_data : '0;
                        end else begin
                            o_stk_pop <= pop_ok;
                        end
                        state <= CMD;
                    end
                end
                CMD: begin
                    o_stk_push <= 1'b0;
                    o_stk_pop  <= 1'b0;
                    o_stk_data <= '0;
                    // A wrapping push on a full stack keeps the count at DEPTH.
                    if (o_stk_push && !o_full) begin
                        o_count <= o_count + (STACK_SIZE+1)'(1);
                    end else if (o_stk_pop) begin
                        o_count <= o_count - (STACK_SIZE+1)'(1);
                    end
                    o_rsp_valid <= NUM_REQ'(1) << owner;
                    o_rsp_err   <= !(o_stk_push || o_stk_pop);
                    o_rsp_data  <= o_stk_pop ? i_stk_data : '0;
                    state       <= RSP;
                end
                RSP: begin
                    o_rsp_valid <= '0;
                    o_rsp_data  <= '0;
                    o_rsp_err   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
